ram_sp_pipe: RTL
================

Name: ram_sp_pipe

Overview:
- Parametrised single-port synchronous RAM. Next generation of the team's 8-bit x 1024 chip-select RAM.
- Adds separate read/write data buses, per-byte write enables, a configurable read-latency pipeline with `rvalid`, a selectable read-during-write mode, a post-reset memory clear state machine and an error flag.
- Sits behind bus masters and register files as local scratch storage.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8. BE_W = DATA_W/8.
- ADDR_W, 10: address width.
- DEPTH, 1024: number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in cycles, from request edge to `rvalid`; legal range 1..4.
- RDW_MODE, 0: read-during-write behaviour. 0 = old data returned; 1 = new (merged) data returned.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset before accepting requests.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select; a request is considered only when high.
- wr  input  1  write request.
- rd  input  1  read request.
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- be  input  BE_W  byte enables; bit i covers wdata[8i+7:8i].
- rdata  output  DATA_W  read data; valid only when rvalid=1.
- rvalid  output  1  one-cycle pulse per accepted read.
- busy  output  1  high while clearing; all requests are ignored while high.
- err  output  1  one-cycle pulse flagging an illegal request.

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - rdata = 0, rvalid = 0, err = 0.
  - all read pipeline stages are invalid.
  - busy = CLEAR_ON_RESET.
  - FSM state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - clear counter = 0.
- The memory array itself has no reset.
- FSM states:
  - CLEAR: each cycle, write 0 to mem[cnt] and increment cnt. When cnt == DEPTH-1, go to IDLE on that edge. busy deasserts in the first IDLE cycle. Clear takes exactly DEPTH cycles after rst_n rises.
  - IDLE: busy = 0; requests are serviced. There is no other exit except reset.
- Reset asserted mid-clear or mid-read: all pipeline stages are flushed, no rvalid is produced for in-flight reads, and the clear restarts from address 0.
- Request decode, only when busy = 0 and cs = 1:
  - wr=1, rd=0: write. For each i with be[i]=1, mem[addr] byte i <= wdata byte i; other bytes are unchanged. be = 0 is a legal no-op with no err.
  - rd=1, wr=0: read accepted. The word enters the pipeline; rdata and rvalid appear exactly RD_LAT edges later. Back-to-back reads are accepted every cycle, so throughput is 1 per cycle.
  - rd=1, wr=1: no access; err pulses on the next cycle.
  - addr >= DEPTH on a read or write: no write, read returns 0 with rvalid still produced, and err pulses on the next cycle.
- Requests while busy=1 or cs=0 are ignored: no err and no rvalid.
- rdata holds its last value when rvalid = 0.
- Read-during-write applies to the same address within the RD_LAT window (a write landing before a pending read's sample point):
  - The array is sampled at the request edge.
  - RDW_MODE = 0: the read returns the pre-write contents.
  - RDW_MODE = 1: a pending read in the pipeline whose address matches a later write is patched with the written bytes (per be) before output.
- Pipeline: RD_LAT-deep shift of {valid, addr, data}. The stage-1 data register is the memory output; stages 2..RD_LAT are plain registers.
- Widths: the clear counter is ADDR_W+1 bits, so DEPTH = 2**ADDR_W does not wrap to 0 early. Address compare is unsigned.

Test Plan:
- Clear: reset released with DEPTH=1024 → busy=1 for exactly 1024 cycles; a read of addr 0x3FF right after busy falls returns 0x00000000 with rvalid RD_LAT cycles later.
- Byte enables: write 0xAABBCCDD at addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 5 → rdata=0xAA22CC44.
- Latency and throughput: RD_LAT=3, reads to addrs 1,2,3 on consecutive cycles (contents 0x10,0x20,0x30) → rvalid high for 3 consecutive cycles starting 3 edges after the first request, data 0x10,0x20,0x30 in order.
- Read-during-write: RD_LAT=2, mem[7]=0x1, read addr 7 followed next cycle by write 0x9 to addr 7 with be all ones → RDW_MODE=0 returns 0x1; RDW_MODE=1 returns 0x9.
- Errors: cs=rd=wr=1 at addr 3 → err pulses once, mem[3] unchanged, no rvalid. DEPTH=1000, write to addr 1000 → err pulses; reading addr 1000 returns 0 with rvalid and err.
- Reset mid-operation: assert rst_n low during a clear at cnt=500 with 2 reads in flight → rvalid stays 0, busy=1, the clear restarts and busy falls 1024 cycles after release; requests with cs=1 issued while busy produce no rvalid and no err.

Source files
------------

// File: rtl/ram_sp_pipe_if.sv
// Request/response bundle for the pipelined single-port RAM.
// master: cs/wr/rd/addr/wdata/be out; slave: rdata/rvalid/busy/err out.
interface ram_sp_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    localparam int BE_W = DATA_W / 8;

    logic              cs;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              err;

    modport master (
        output cs, wr, rd, addr, wdata, be,
        input  rdata, rvalid, busy, err
    );

    modport slave (
        input  cs, wr, rd, addr, wdata, be,
        output rdata, rvalid, busy, err
    );
endinterface

// File: rtl/ram_sp_pipe.sv
// Single-port RAM: byte enables, RD_LAT read pipe, RDW mode, clear FSM.
// Ports: clk, rst_n (async low), bus (slave: req in, rdata/rvalid/busy/err).
module ram_sp_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_sp_pipe_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] LIM  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam bit PATCH = (RDW_MODE != 0);
    localparam bit CLR   = (CLEAR_ON_RESET != 0);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state;
    logic              busy_q;
    logic              err_q;
    logic [ADDR_W:0]   cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              pv [RD_LAT];
    logic [ADDR_W-1:0] pa [RD_LAT];
    logic [DATA_W-1:0] pd [RD_LAT];

    logic req, in_range, do_wr, do_rd, bad;

    assign req      = ~busy_q & bus.cs;
    assign in_range = {1'b0, bus.addr} < LIM;
    assign do_wr    = req & bus.wr & ~bus.rd & in_range;
    assign do_rd    = req & bus.rd & ~bus.wr;
    assign bad      = req & ((bus.rd & bus.wr) |
                      ((bus.rd | bus.wr) & ~in_range));

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] nw,
        input logic [BE_W-1:0]   b
    );
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < BE_W; i++)
            if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLR ? S_CLEAR : S_IDLE;
            busy_q <= CLR;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= bad;
            unique case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_IDLE:  busy_q <= 1'b0;
                default: state  <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; the clear sweep and bus writes share one port.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt[ADDR_W-1:0]] <= '0;
        end else if (do_wr) begin
            for (int i = 0; i < BE_W; i++)
                if (bus.be[i])
                    mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
    end

    // Data only moves with a valid token, so the last stage holds rdata.
    // In new-data mode a write hitting a pending read patches it in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pv[k] <= 1'b0;
                pa[k] <= '0;
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= do_rd;
            if (do_rd) begin
                pa[0] <= bus.addr;
                pd[0] <= in_range ? mem[bus.addr] : '0;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    pa[k] <= pa[k-1];
                    if (PATCH && do_wr && bus.addr == pa[k-1])
                        pd[k] <= merge(pd[k-1], bus.wdata, bus.be);
                    else
                        pd[k] <= pd[k-1];
                end
            end
        end
    end

    assign bus.rdata  = pd[RD_LAT-1];
    assign bus.rvalid = pv[RD_LAT-1];
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;
endmodule
